// File: rtl/bp_be_pkg.sv
// Shared types for the BE checker loop-inference scheduler: processor config
// selector, virtual-address width lookup and the scheduler state encoding.
// No logic; imported by the scheduler and its arbitration helpers.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    // Virtual-address width implied by a processor configuration.
    function automatic int bp_vaddr_width(bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_default_cfg: w = 39;
            default:          w = 39;
        endcase
        return w;
    endfunction

    typedef enum logic [2:0] {
        e_sched_idle   = 3'd0,
        e_sched_launch = 3'd1,
        e_sched_wait   = 3'd2,
        e_sched_drain  = 3'd3,
        e_sched_flush  = 3'd4
    } bp_be_loop_sched_state_e;

endpackage

// File: rtl/bp_be_loop_inference_sched_arb.sv
// Arbitration helpers: round-robin pick starting at an external pointer, and
// one-hot to index encoder. Purely combinational, zero latency, no backpressure.
// Ports: reqs_i/ptr_i -> grants_o (arbiter); i -> addr_o/v_o (encoder).
module bsg_arb_round_robin #(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0]         reqs_i,
    input  logic [$clog2(width_p)-1:0] ptr_i,
    output logic [width_p-1:0]         grants_o
);
    localparam int idx_w_lp = $clog2(width_p);

    logic [idx_w_lp-1:0] idx;
    logic                found;

    // width_p is a power of two, so the index sum wraps naturally.
    always_comb begin
        grants_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < width_p; i++) begin
            idx = ptr_i + idx_w_lp'(i);
            if (!found && reqs_i[idx]) begin
                grants_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end
endmodule

module bsg_encode_one_hot #(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0]         i,
    output logic [$clog2(width_p)-1:0] addr_o,
    output logic                       v_o
);
    localparam int idx_w_lp = $clog2(width_p);

    always_comb begin
        addr_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (i[k]) addr_o = addr_o | idx_w_lp'(k);
        end
    end

    assign v_o = |i;
endmodule

// File: rtl/bp_be_loop_inference_sched.sv
// Round-robin scheduler for the shared loop-inference engine: grants one
// striding-load detector at a time, sequences launch/confirm/result/timeout and
// returns one tagged result per grant. Grant 1 cycle after request; result 1
// cycle after engine valid or after the last WAIT cycle; result held until
// result_yumi_i, new grants stall while busy_o.
// Ports: req_* from detectors, *_discovery_o/striding_pc_o/iters_* to/from
// the engine, result_* to prefetch logic, busy_o while not idle.
module bp_be_loop_inference_sched
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_default_cfg,
    parameter int         num_req_p      = 4,
    parameter int         output_range_p = 8,
    parameter int         timeout_p      = 256
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic [num_req_p-1:0]                             req_v_i,
    input  logic [num_req_p*bp_vaddr_width(bp_params_p)-1:0] req_pc_i,
    input  logic [num_req_p-1:0]                             req_confirm_i,
    output logic [num_req_p-1:0]                             req_grant_o,
    output logic                                             start_discovery_o,
    output logic                                             confirm_discovery_o,
    output logic [bp_vaddr_width(bp_params_p)-1:0]           striding_pc_o,
    input  logic                                             iters_v_i,
    input  logic [output_range_p-1:0]                        iters_i,
    output logic                                             iters_yumi_o,
    output logic                                             result_v_o,
    output logic [$clog2(num_req_p)-1:0]                     result_id_o,
    output logic [output_range_p-1:0]                        result_iters_o,
    output logic                                             result_timeout_o,
    input  logic                                             result_yumi_i,
    output logic                                             busy_o
);
    localparam int vaddr_width_lp = bp_vaddr_width(bp_params_p);
    localparam int id_width_lp    = $clog2(num_req_p);
    localparam int timer_width_lp = $clog2(timeout_p);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

    bp_be_loop_sched_state_e state_r, state_n;

    logic [id_width_lp-1:0]    ptr_r, owner_r;
    logic [vaddr_width_lp-1:0] pc_r;
    logic [timer_width_lp-1:0] timer_r;
    logic                      confirmed_r;
    logic [output_range_p-1:0] res_iters_r;
    logic                      res_timeout_r;
    // FLUSH bookkeeping: late engine answer discarded / result handed over.
    logic                      discarded_r;
    logic                      taken_r;

    logic [num_req_p-1:0]      arb_grants;
    logic [id_width_lp-1:0]    arb_idx;
    logic                      arb_v;
    logic [vaddr_width_lp-1:0] pc_sel;
    logic                      timer_expire;
    logic                      flush_done;

    bsg_arb_round_robin #(.width_p(num_req_p)) arb (
        .reqs_i   (req_v_i),
        .ptr_i    (ptr_r),
        .grants_o (arb_grants)
    );

    bsg_encode_one_hot #(.width_p(num_req_p)) enc (
        .i      (arb_grants),
        .addr_o (arb_idx),
        .v_o    (arb_v)
    );

    always_comb begin
        pc_sel = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (arb_idx == id_width_lp'(i)) pc_sel = req_pc_i[i*vaddr_width_lp +: vaddr_width_lp];
        end
    end

    assign timer_expire = (timer_r == timer_last_lp);
    // FLUSH exits once both the late answer and the result handoff are seen,
    // in either order or in the same cycle.
    assign flush_done   = (discarded_r | iters_v_i) & (taken_r | result_yumi_i);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_sched_idle;
        else         state_r <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_sched_idle:   if (arb_v) state_n = e_sched_launch;
            e_sched_launch: state_n = e_sched_wait;
            e_sched_wait: begin
                if (iters_v_i)         state_n = e_sched_drain;
                else if (timer_expire) state_n = confirmed_r ? e_sched_flush : e_sched_drain;
            end
            e_sched_drain:  if (result_yumi_i) state_n = e_sched_idle;
            e_sched_flush:  if (flush_done)    state_n = e_sched_idle;
            default:        state_n = e_sched_idle;
        endcase
    end

    // Output logic
    always_comb begin
        req_grant_o         = '0;
        start_discovery_o   = 1'b0;
        confirm_discovery_o = 1'b0;
        iters_yumi_o        = 1'b0;
        result_v_o          = 1'b0;
        case (state_r)
            e_sched_launch: begin
                start_discovery_o = 1'b1;
                req_grant_o       = num_req_p'(1) << owner_r;
            end
            e_sched_wait: begin
                confirm_discovery_o = req_confirm_i[owner_r] & ~confirmed_r;
                iters_yumi_o        = iters_v_i;
            end
            e_sched_drain:  result_v_o = 1'b1;
            e_sched_flush: begin
                result_v_o   = ~taken_r;
                iters_yumi_o = iters_v_i & ~discarded_r;
            end
            default: ;
        endcase
    end

    assign busy_o           = (state_r != e_sched_idle);
    assign striding_pc_o    = busy_o ? pc_r : '0;
    assign result_id_o      = result_v_o ? owner_r : '0;
    assign result_iters_o   = result_v_o ? res_iters_r : '0;
    assign result_timeout_o = result_v_o & res_timeout_r;

    // Datapath
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r         <= '0;
            owner_r       <= '0;
            pc_r          <= '0;
            timer_r       <= '0;
            confirmed_r   <= 1'b0;
            res_iters_r   <= '0;
            res_timeout_r <= 1'b0;
            discarded_r   <= 1'b0;
            taken_r       <= 1'b0;
        end else begin
            case (state_r)
                e_sched_idle: begin
                    if (arb_v) begin
                        owner_r <= arb_idx;
                        pc_r    <= pc_sel;
                    end
                end
                e_sched_launch: begin
                    timer_r     <= '0;
                    confirmed_r <= 1'b0;
                    discarded_r <= 1'b0;
                    taken_r     <= 1'b0;
                end
                e_sched_wait: begin
                    // Saturate rather than wrap; expiry leaves WAIT anyway.
                    if (!timer_expire) timer_r <= timer_r + timer_width_lp'(1);
                    if (confirm_discovery_o) confirmed_r <= 1'b1;
                    if (iters_v_i) begin
                        res_iters_r   <= iters_i;
                        res_timeout_r <= 1'b0;
                    end else if (timer_expire) begin
                        res_iters_r   <= '0;
                        res_timeout_r <= 1'b1;
                    end
                end
                e_sched_drain: begin
                    if (result_yumi_i) ptr_r <= owner_r + id_width_lp'(1);
                end
                e_sched_flush: begin
                    if (iters_yumi_o)               discarded_r <= 1'b1;
                    if (result_v_o && result_yumi_i) taken_r    <= 1'b1;
                    if (flush_done) ptr_r <= owner_r + id_width_lp'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
module tb_bp_be_loop_inference_sched;
    import bp_be_pkg::*;

    localparam int N  = 4;
    localparam int VA = 39;
    localparam int OR = 8;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [N-1:0]  req_v;
    logic [N*VA-1:0] req_pc;
    logic [N-1:0]  req_confirm;
    logic [N-1:0]  req_grant_o;
    logic          start_discovery_o;
    logic          confirm_discovery_o;
    logic [VA-1:0] striding_pc_o;
    logic          iters_v;
    logic [OR-1:0] iters;
    logic          iters_yumi_o;
    logic          result_v_o;
    logic [1:0]    result_id_o;
    logic [OR-1:0] result_iters_o;
    logic          result_timeout_o;
    logic          result_yumi;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_be_loop_inference_sched #(
        .bp_params_p    (e_bp_default_cfg),
        .num_req_p      (N),
        .output_range_p (OR),
        .timeout_p      (TO)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .req_v_i             (req_v),
        .req_pc_i            (req_pc),
        .req_confirm_i       (req_confirm),
        .req_grant_o         (req_grant_o),
        .start_discovery_o   (start_discovery_o),
        .confirm_discovery_o (confirm_discovery_o),
        .striding_pc_o       (striding_pc_o),
        .iters_v_i           (iters_v),
        .iters_i             (iters),
        .iters_yumi_o        (iters_yumi_o),
        .result_v_o          (result_v_o),
        .result_id_o         (result_id_o),
        .result_iters_o      (result_iters_o),
        .result_timeout_o    (result_timeout_o),
        .result_yumi_i       (result_yumi),
        .busy_o              (busy_o)
    );

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic set_pc(input int i, input logic [VA-1:0] v);
        req_pc[i*VA +: VA] = v;
    endtask

    // Advances until start_discovery_o is seen (bounded); leaves time in the LAUNCH cycle.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (start_discovery_o) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset;
        logic [5:0] got;
        reset_i = 1'b1; req_v = '0; req_pc = '0; req_confirm = '0;
        iters_v = 1'b1; iters = 8'hAA; result_yumi = 1'b0;
        #3;
        got = {busy_o, start_discovery_o, confirm_discovery_o, iters_yumi_o, result_v_o, result_timeout_o};
        checks++;
        if (got !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", got); end
        checks++;
        if ({req_grant_o, striding_pc_o, result_id_o, result_iters_o} !== '0) begin
            errors++; $display("FAIL reset_data got grant=%b pc=%h id=%0d it=%0d want all 0",
                               req_grant_o, striding_pc_o, result_id_o, result_iters_o);
        end
        step(); step();
        reset_i = 1'b0; iters_v = 1'b0; iters = '0;
        step();
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy_o); end
    endtask

    task automatic test_round_robin;
        bit ok;
        int exp;
        logic [11:0] got_t, exp_t;
        for (int i = 0; i < N; i++) set_pc(i, 39'h1000 + 39'(i * 256));
        req_v = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            wait_start(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rr_start%0d no launch within bound", k); req_v = '0; return; end
            checks++;
            if (req_grant_o !== (4'b0001 << exp)) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_grant_o, 4'b0001 << exp);
            end
            checks++;
            if (striding_pc_o !== 39'h1000 + 39'(exp * 256)) begin
                errors++; $display("FAIL rr_pc%0d got %h want %h", k, striding_pc_o, 39'h1000 + 39'(exp * 256));
            end
            for (int c = 0; c < 5; c++) step();
            iters_v = 1'b1; iters = 8'(10 + k);
            #1;
            checks++;
            if (iters_yumi_o !== 1'b1) begin errors++; $display("FAIL rr_yumi%0d got %b want 1", k, iters_yumi_o); end
            step();
            iters_v = 1'b0;
            #1;
            got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
            exp_t = {1'b1, 2'(exp), 8'(10 + k), 1'b0};
            checks++;
            if (got_t !== exp_t) begin errors++; $display("FAIL rr_result%0d got %h want %h", k, got_t, exp_t); end
            result_yumi = 1'b1;
            step();
            result_yumi = 1'b0;
            if (k == 4) req_v = '0;
        end
    endtask

    task automatic test_single;
        bit ok;
        bit early;
        logic [11:0] got_t;
        set_pc(2, 39'h8000_1000);
        req_v = 4'b0100;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_start no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_grant_o); end
        checks++;
        if (striding_pc_o !== 39'h8000_1000) begin errors++; $display("FAIL single_pc got %h want 80001000", striding_pc_o); end
        req_v = '0;
        set_pc(2, 39'h1234);
        early = 1'b0;
        for (int c = 1; c < 20; c++) begin
            step();
            #1;
            if (result_v_o || striding_pc_o !== 39'h8000_1000) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL single_wait got early result or pc change want none"); end
        step();
        iters_v = 1'b1; iters = 8'd37;
        #1;
        checks++;
        if (iters_yumi_o !== 1'b1) begin errors++; $display("FAIL single_yumi got %b want 1", iters_yumi_o); end
        step();
        iters_v = 1'b0;
        #1;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd2, 8'd37, 1'b0}) begin errors++; $display("FAIL single_result got %h want %h", got_t, {1'b1, 2'd2, 8'd37, 1'b0}); end
        step();
        iters_v = 1'b1; iters = 8'd5;
        #1;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd2, 8'd37, 1'b0}) begin errors++; $display("FAIL single_hold got %h want %h", got_t, {1'b1, 2'd2, 8'd37, 1'b0}); end
        checks++;
        if (iters_yumi_o !== 1'b0) begin errors++; $display("FAIL drain_no_ack got %b want 0", iters_yumi_o); end
        iters_v = 1'b0;
        result_yumi = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b want 1", busy_o); end
        step();
        result_yumi = 1'b0;
        #1;
        checks++;
        if ({busy_o, result_v_o, striding_pc_o} !== '0) begin
            errors++; $display("FAIL single_idle got busy=%b rv=%b pc=%h want 0", busy_o, result_v_o, striding_pc_o);
        end
    endtask

    task automatic test_confirm;
        bit ok;
        int pulses, pcyc;
        logic [11:0] got_t;
        set_pc(0, 39'h2000);
        req_v = 4'b0001;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL conf_start no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b0001 || confirm_discovery_o !== 1'b0) begin
            errors++; $display("FAIL conf_launch got grant=%b conf=%b want 0001/0", req_grant_o, confirm_discovery_o);
        end
        req_v = '0;
        pulses = 0; pcyc = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) req_confirm = 4'b0001;
            #1;
            if (confirm_discovery_o) begin pulses++; pcyc = k; end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL conf_count got %0d want 1", pulses); end
        checks++;
        if (pcyc != 4) begin errors++; $display("FAIL conf_cycle got %0d want 4", pcyc); end
        step();
        iters_v = 1'b1; iters = 8'd5;
        step();
        iters_v = 1'b0; req_confirm = '0;
        #1;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd0, 8'd5, 1'b0}) begin errors++; $display("FAIL conf_result got %h want %h", got_t, {1'b1, 2'd0, 8'd5, 1'b0}); end
        result_yumi = 1'b1;
        step();
        result_yumi = 1'b0;
    endtask

    task automatic test_timeout;
        bit ok;
        bit early;
        logic [11:0] got_t;
        set_pc(1, 39'h3000);
        req_v = 4'b0010;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_start no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", req_grant_o); end
        req_v = '0;
        early = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            step();
            #1;
            if (result_v_o) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL to_early got result before cycle %0d want none", TO + 1); end
        step();
        #1;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd1, 8'd0, 1'b1}) begin errors++; $display("FAIL to_result got %h want %h", got_t, {1'b1, 2'd1, 8'd0, 1'b1}); end
        result_yumi = 1'b1;
        step();
        result_yumi = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL to_idle busy got %b want 0", busy_o); end
    endtask

    task automatic test_async_reset;
        bit ok;
        logic [11:0] got_t;
        req_v = 4'b0010;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_start no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b0010) begin errors++; $display("FAIL ar_grant got %b want 0010", req_grant_o); end
        req_v = '0;
        step(); step(); step();
        reset_i = 1'b1; iters_v = 1'b1; iters = 8'd9;
        #1;
        checks++;
        if ({busy_o, start_discovery_o, confirm_discovery_o, iters_yumi_o, result_v_o, result_timeout_o,
             req_grant_o, striding_pc_o, result_iters_o, result_id_o} !== '0) begin
            errors++; $display("FAIL ar_outputs got busy=%b yumi=%b pc=%h want all 0", busy_o, iters_yumi_o, striding_pc_o);
        end
        step();
        reset_i = 1'b0; iters_v = 1'b0;
        step();
        #1;
        checks++;
        if ({busy_o, result_v_o} !== 2'b00) begin errors++; $display("FAIL ar_no_result got %b want 00", {busy_o, result_v_o}); end
        req_v = 4'hF;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_restart no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b0001) begin errors++; $display("FAIL ar_ptr0 got %b want 0001", req_grant_o); end
        req_v = '0;
        step();
        iters_v = 1'b1; iters = 8'd7;
        step();
        iters_v = 1'b0;
        #1;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd0, 8'd7, 1'b0}) begin errors++; $display("FAIL ar_result got %h want %h", got_t, {1'b1, 2'd0, 8'd7, 1'b0}); end
        result_yumi = 1'b1;
        step();
        result_yumi = 1'b0;
    endtask

    task automatic test_flush;
        bit ok;
        bit idle_early;
        int pulses;
        logic [11:0] got_t;
        set_pc(3, 39'h4000);
        req_v = 4'b1000;
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fl_start no launch within bound"); req_v = '0; return; end
        checks++;
        if (req_grant_o !== 4'b1000) begin errors++; $display("FAIL fl_grant got %b want 1000", req_grant_o); end
        req_v = '0;
        step();
        req_confirm = 4'b1000;
        #1;
        checks++;
        if (confirm_discovery_o !== 1'b1) begin errors++; $display("FAIL fl_confirm got %b want 1", confirm_discovery_o); end
        pulses = confirm_discovery_o ? 1 : 0;
        for (int k = 2; k <= TO; k++) begin
            step();
            #1;
            if (confirm_discovery_o) pulses++;
        end
        step();
        #1;
        if (confirm_discovery_o) pulses++;
        got_t = {result_v_o, result_id_o, result_iters_o, result_timeout_o};
        checks++;
        if (got_t !== {1'b1, 2'd3, 8'd0, 1'b1}) begin errors++; $display("FAIL fl_result got %h want %h", got_t, {1'b1, 2'd3, 8'd0, 1'b1}); end
        result_yumi = 1'b1;
        step();
        result_yumi = 1'b0;
        #1;
        checks++;
        if ({result_v_o, busy_o} !== 2'b01) begin errors++; $display("FAIL fl_after_yumi got rv/busy=%b want 01", {result_v_o, busy_o}); end
        idle_early = 1'b0;
        for (int j = 3; j <= 9; j++) begin
            step();
            #1;
            if (!busy_o || result_v_o) idle_early = 1'b1;
        end
        checks++;
        if (idle_early) begin errors++; $display("FAIL fl_hold got idle or result before discard want busy"); end
        step();
        iters_v = 1'b1; iters = 8'd99;
        #1;
        checks++;
        if (iters_yumi_o !== 1'b1) begin errors++; $display("FAIL fl_discard got %b want 1", iters_yumi_o); end
        step();
        iters_v = 1'b0; req_confirm = '0;
        #1;
        checks++;
        if ({busy_o, result_v_o} !== 2'b00) begin errors++; $display("FAIL fl_idle got %b want 00", {busy_o, result_v_o}); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL fl_confirm_once got %0d want 1", pulses); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_confirm();
        test_timeout();
        test_async_reset();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
